mvd_eg_decode: RTL and testbench
================================

# mvd_eg_decode

Sequential decoder for the motion-vector-difference syntax whose cost the encoder estimates from mv − mvp. It consumes a serial bit stream carrying two signed Exp-Golomb order-0 codewords, mvd_x first and mvd_y second. It reconstructs mv = mvp + mvd and reports the decoded MVD together with the number of bits consumed. The block sits in the reconstruction/MC check path, where it acts as the receiving end for encoded MVDs.

## Interface
- FMV_W, default 10: width of one MV component; top level instantiates with `FMV_WIDTH.
- MVD_W, default 11: width of one MVD component; top level instantiates with `MVD_WIDTH.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  pulse that begins a decode; accepted only in IDLE.
- mvp_i  in  2*FMV_W  predictor, {y, x}; x in [FMV_W-1:0]; sampled on the accepted start_i.
- bit_i  in  1  serial code bit.
- bit_val_i  in  1  bit_i is valid this cycle.
- bit_rdy_o  out  1  block accepts a bit this cycle.
- done_o  out  1  one-cycle pulse; result outputs valid from this cycle onward.
- err_o  out  1  pulses with done_o when the codeword is illegal.
- mv_o  out  2*FMV_W  reconstructed MV, {y, x}.
- mvd_o  out  2*MVD_W  decoded MVD, {x, y}; x is in the upper half.
- mv_bits_cnt_o  out  7  total bits consumed for the pair.

## Operation
- States: IDLE, X_PRE, X_SUF, Y_PRE, Y_SUF, DONE.
- A bit transfers when bit_val_i & bit_rdy_o. bit_rdy_o = 1 only in the PRE/SUF states.
- IDLE: on start_i, latch mvp_i, clear the bit counter and go to X_PRE. start_i in any other state is ignored.
- PRE (per component): count the leading zeros L.
  - On a '1', set val = 1.
  - If L = 0, the codeword is complete: codeNum k = 0. Go to the next component's PRE, or to DONE after y.
  - If L > 0, go to SUF.
- SUF: shift in L bits, val = (val<<1)|bit. After the L-th bit, k = val − 1.
- Sign mapping: odd k gives mvd = +(k+1)/2; even k gives mvd = −k/2.
- Error cases, both assert err_o with done_o and go to DONE:
  - The (MVD_W+1)-th consecutive prefix zero: terminate immediately.
  - mvd outside [−2^(MVD_W-1), 2^(MVD_W-1)−1] (possible only when L = MVD_W).
  - On error, mvd_o and mv_o load 0, and mv_bits_cnt_o holds the bits consumed so far.
- Reconstruction: mv_c = mvp_c + mvd_c (mvd_c sign-extended), truncated to FMV_W bits with two's-complement wrap.
- mv_bits_cnt_o = Σ(2L+1) over both components, or the partial count on error. The maximum is 46, so 7 bits never overflow.
- DONE: pulse done_o, register the outputs and return to IDLE in the next cycle.
- Outputs hold their values until the next DONE.

## Timing
- Reset: state IDLE. mv_o, mvd_o, mv_bits_cnt_o, done_o, err_o and bit_rdy_o are all 0.
- Reset mid-decode aborts immediately; no done_o is produced.
- Start accepted in cycle 0 → bit_rdy_o = 1 from cycle 1.
- With bit_val_i held high, done_o is asserted in cycle N+1, where N = total bits.
- Stalls (bit_val_i = 0) delay completion one cycle each; no state changes during a stall.
- bit_rdy_o is 0 in IDLE and in DONE, so bits offered there are not consumed.
- Back-to-back decodes are allowed: a start_i in the cycle after done_o is accepted.

## Test plan
- mvp = (x=5, y=−3), bits 1,1, bit_val_i always high:
  - mvd = (0, 0), mv = (5, −3), cnt = 2.
  - done_o in cycle 3, err_o = 0.
- mvp = (0, 0), x bits 010 (k=1 → +1), y bits 011 (k=2 → −1):
  - mvd_o = {+1, −1}, mv = (1, −1), cnt = 6.
- x bits 00100 (k=3 → +2), y bits 00111 (k=6 → −3), bit_val_i high on alternate cycles only:
  - mvd = (2, −3), cnt = 10.
  - done_o 20 cycles after start.
- Wrap: mvp x = 511, y = 0; bits 010, 1:
  - mv x = −512, y = 0, cnt = 4.
- Illegal prefix: 12 consecutive zeros in x:
  - err_o = done_o = 1 in the cycle after the 12th zero.
  - cnt = 12, mv = mvd = 0.
- Robustness:
  - rst_n low during X_SUF → all outputs 0, state IDLE.
  - start_i asserted during Y_PRE → ignored; the decode in progress completes correctly.
  - A fresh decode after reset matches the first test's results.

Source files
------------

// File: rtl/mvd_eg_decode_if.sv
// mvd_eg_decode_if: start/bit-stream handshake and result bus of the MVD Exp-Golomb decoder.
interface mvd_eg_decode_if #(
  parameter int FMV_W = 10,
  parameter int MVD_W = 11
);
  logic               start_i;
  logic [2*FMV_W-1:0] mvp_i;
  logic               bit_i;
  logic               bit_val_i;
  logic               bit_rdy_o;
  logic               done_o;
  logic               err_o;
  logic [2*FMV_W-1:0] mv_o;
  logic [2*MVD_W-1:0] mvd_o;
  logic [6:0]         mv_bits_cnt_o;
  modport master (
    output start_i, mvp_i, bit_i, bit_val_i,
    input  bit_rdy_o, done_o, err_o, mv_o, mvd_o, mv_bits_cnt_o
  );
  modport slave (
    input  start_i, mvp_i, bit_i, bit_val_i,
    output bit_rdy_o, done_o, err_o, mv_o, mvd_o, mv_bits_cnt_o
  );
endinterface

// File: rtl/mvd_eg_decode.sv
// mvd_eg_decode: serial signed Exp-Golomb order-0 decoder for an (x, y) MVD pair,
// reconstructing mv = mvp + mvd and counting the bits consumed.
module mvd_eg_decode #(
  parameter int FMV_W = 10,
  parameter int MVD_W = 11
) (
  input logic clk,
  input logic rst_n,
  mvd_eg_decode_if.slave bus
);
  typedef enum logic [2:0] {IDLE, X_PRE, X_SUF, Y_PRE, Y_SUF, DONE} state_t;
  localparam int LW = $clog2(MVD_W + 2);
  localparam logic [MVD_W-1:0] HALF = {1'b1, {(MVD_W-1){1'b0}}};
  state_t state, state_n;
  logic [LW-1:0] zc;
  logic [MVD_W:0] val, fin_val;
  logic [6:0] cnt, cnt_q;
  logic [2*FMV_W-1:0] mvp, mv_q;
  logic [MVD_W-1:0] mvd_x, mvd_c, mag;
  logic [2*MVD_W-1:0] mvd_q;
  logic [FMV_W+MVD_W-1:0] sum_x, sum_y;
  logic err, pre, suf, xfer, pos, in_range, comp_done, last, bad;
  assign pre = state == X_PRE || state == Y_PRE;
  assign suf = state == X_SUF || state == Y_SUF;
  assign xfer = bus.bit_val_i & bus.bit_rdy_o;
  assign fin_val = pre ? (MVD_W+1)'(1) : {val[MVD_W-1:0], bus.bit_i};
  // val = codeNum + 1, so |mvd| = val >> 1 and the sign is positive when val is even
  assign mag = fin_val[MVD_W:1];
  assign pos = ~fin_val[0];
  assign in_range = pos ? mag < HALF : mag <= HALF;
  assign mvd_c = pos ? mag : -mag;
  assign comp_done = xfer & (pre ? bus.bit_i & (zc == '0) : zc == LW'(1));
  assign last = comp_done & (state == Y_PRE || state == Y_SUF);
  assign bad = (xfer & pre & ~bus.bit_i & (zc == LW'(MVD_W))) | (comp_done & ~in_range);
  assign sum_x = {{MVD_W{mvp[FMV_W-1]}}, mvp[FMV_W-1:0]} + {{FMV_W{mvd_x[MVD_W-1]}}, mvd_x};
  assign sum_y = {{MVD_W{mvp[2*FMV_W-1]}}, mvp[2*FMV_W-1:FMV_W]} + {{FMV_W{mvd_c[MVD_W-1]}}, mvd_c};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start_i ? X_PRE : IDLE;
      X_PRE:   state_n = bad ? DONE : comp_done ? Y_PRE : (xfer & bus.bit_i) ? X_SUF : X_PRE;
      X_SUF:   state_n = bad ? DONE : comp_done ? Y_PRE : X_SUF;
      Y_PRE:   state_n = (bad | comp_done) ? DONE : (xfer & bus.bit_i) ? Y_SUF : Y_PRE;
      Y_SUF:   state_n = (bad | comp_done) ? DONE : Y_SUF;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      zc <= '0;
      val <= '0;
      cnt <= '0;
      mvp <= '0;
      mvd_x <= '0;
      err <= 1'b0;
      mv_q <= '0;
      mvd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (state == IDLE && bus.start_i) begin
        mvp <= bus.mvp_i;
        cnt <= '0;
        zc <= '0;
      end
      if (xfer) begin
        cnt <= cnt + 7'd1;
        zc <= pre ? zc + LW'(!bus.bit_i) : zc - LW'(1);
        val <= fin_val;
      end
      if (comp_done && !last) mvd_x <= mvd_c;
      if (bad || last) begin
        err <= bad;
        mvd_q <= bad ? '0 : {mvd_x, mvd_c};
        mv_q <= bad ? '0 : {sum_y[FMV_W-1:0], sum_x[FMV_W-1:0]};
        cnt_q <= cnt + 7'd1;
      end
    end
  assign bus.bit_rdy_o = pre | suf;
  assign bus.done_o = state == DONE;
  assign bus.err_o = (state == DONE) & err;
  assign bus.mv_o = mv_q;
  assign bus.mvd_o = mvd_q;
  assign bus.mv_bits_cnt_o = cnt_q;
endmodule

// File: tb/tb_mvd_eg_decode.sv
// tb_mvd_eg_decode: directed and random MVD pairs, encoded by a reference Exp-Golomb
// encoder in the bench and checked against the decoder's results and timing.
module tb_mvd_eg_decode;
  localparam int FW = 10;
  localparam int DW = 11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  bit bq[$];

  mvd_eg_decode_if #(.FMV_W(FW), .MVD_W(DW)) bus();
  mvd_eg_decode #(.FMV_W(FW), .MVD_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] wrap(input int a);
    return FW'(a);
  endfunction

  function automatic logic [DW-1:0] dv(input int a);
    return DW'(a);
  endfunction

  // Signed Exp-Golomb encoder: v -> codeNum k -> L zeros then binary(k+1) in L+1 bits
  task automatic push_se(input int v);
    int k, code, l;
    k = v > 0 ? 2 * v - 1 : -2 * v;
    code = k + 1;
    l = 0;
    while ((code >> (l + 1)) != 0) l++;
    repeat (l) bq.push_back(1'b0);
    for (int i = l; i >= 0; i--) bq.push_back(bit'((code >> i) & 1));
  endtask

  task automatic run(input string tag, input int mx, input int my, input int stall,
                     input int start_at, input bit eerr, input int dx, input int dy,
                     input int ecnt, input int ecyc);
    int c, idx;
    bit got;
    c = 1;
    idx = 0;
    got = 1'b0;
    @(negedge clk);
    check({tag, "/prev_done_low"}, bus.done_o, 1'b0);
    bus.start_i = 1'b1;
    bus.mvp_i = {wrap(my), wrap(mx)};
    @(negedge clk);
    bus.start_i = 1'b0;
    while (c < 400 && !got) begin
      if (bus.done_o) got = 1'b1;
      else begin
        bus.start_i = (c == start_at);
        if (c == start_at) bus.mvp_i = ~bus.mvp_i;
        bus.bit_val_i = idx < bq.size() && (stall == 0 || c % 2 == 1);
        bus.bit_i = idx < bq.size() ? bq[idx] : 1'b0;
        if (bus.bit_val_i && bus.bit_rdy_o) idx++;
        @(negedge clk);
        c++;
      end
    end
    bus.bit_val_i = 1'b0;
    bus.start_i = 1'b0;
    check({tag, "/done_seen"}, got, 1'b1);
    if (ecyc > 0) check({tag, "/done_cycle"}, c, ecyc);
    check({tag, "/err"}, bus.err_o, eerr);
    check({tag, "/cnt"}, bus.mv_bits_cnt_o, ecnt);
    check({tag, "/mvd"}, bus.mvd_o, eerr ? '0 : {dv(dx), dv(dy)});
    check({tag, "/mv"}, bus.mv_o, eerr ? '0 : {wrap(my + dy), wrap(mx + dx)});
    bq.delete();
  endtask

  initial begin
    int dx, dy, mx, my, st, w, n;
    bit seen;
    bus.start_i = 1'b0;
    bus.mvp_i = '0;
    bus.bit_i = 1'b0;
    bus.bit_val_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst/done", bus.done_o, 1'b0);
    check("rst/err", bus.err_o, 1'b0);
    check("rst/rdy", bus.bit_rdy_o, 1'b0);
    check("rst/outs", {bus.mv_o, bus.mvd_o, bus.mv_bits_cnt_o}, '0);
    rst_n = 1'b1;

    push_se(0); push_se(0);
    run("zero", 5, -3, 0, -1, 1'b0, 0, 0, 2, 3);
    push_se(1); push_se(-1);
    run("pm1", 0, 0, 0, -1, 1'b0, 1, -1, 6, 7);
    push_se(2); push_se(-3);
    run("stall", 0, 0, 1, -1, 1'b0, 2, -3, 10, 20);
    push_se(1); push_se(0);
    run("wrap", 511, 0, 0, -1, 1'b0, 1, 0, 4, 5);
    repeat (12) bq.push_back(1'b0);
    run("long_prefix", 7, 9, 0, -1, 1'b1, 0, 0, 12, 13);
    repeat (11) bq.push_back(1'b0);
    bq.push_back(1'b1);
    repeat (11) bq.push_back(1'b0);
    run("range_pos", 3, 3, 0, -1, 1'b1, 0, 0, 23, 24);
    push_se(-1024); push_se(1023);
    run("range_edges", 100, -200, 0, -1, 1'b0, -1024, 1023, 44, 45);
    push_se(0); push_se(5);
    run("start_in_ypre", -7, 12, 0, 3, 1'b0, 0, 5, 8, 9);
    @(negedge clk);
    check("start_in_ypre/idle_after", {bus.done_o, bus.bit_rdy_o}, 2'b00);

    bus.start_i = 1'b1;
    bus.mvp_i = {wrap(4), wrap(4)};
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.bit_val_i = 1'b1;
    bus.bit_i = 1'b0;
    @(negedge clk);
    bus.bit_i = 1'b1;
    @(negedge clk);
    bus.bit_val_i = 1'b0;
    check("abort/in_suf_rdy", bus.bit_rdy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort/outs", {bus.mv_o, bus.mvd_o, bus.mv_bits_cnt_o}, '0);
    check("abort/flags", {bus.done_o, bus.err_o, bus.bit_rdy_o}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= bus.done_o | bus.bit_rdy_o;
    end
    check("abort/stays_idle", seen, 1'b0);
    push_se(0); push_se(0);
    run("after_rst", 5, -3, 0, -1, 1'b0, 0, 0, 2, 3);

    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(0, 10);
      dx = int'($urandom_range(0, (2 << w) - 1)) - (1 << w);
      w = $urandom_range(0, 10);
      dy = int'($urandom_range(0, (2 << w) - 1)) - (1 << w);
      mx = int'($urandom_range(0, 1023)) - 512;
      my = int'($urandom_range(0, 1023)) - 512;
      st = $urandom_range(0, 1);
      push_se(dx); push_se(dy);
      n = bq.size();
      run($sformatf("rand%0d", i), mx, my, st, -1, 1'b0, dx, dy, n, st != 0 ? 2 * n : n + 1);
    end
    @(negedge clk);
    check("end/idle", {bus.done_o, bus.bit_rdy_o}, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
